// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32 front-end types.
//   word            - 32-bit machine word
//   fetch_entry_t   - one fetch-to-decode payload {pc, pc4, inst}
//   FETCH_BUF_DEPTH_MAX - upper bound on fetch_buffer DEPTH
package rv32;

   localparam int unsigned XLEN                = 32;
   localparam int unsigned FETCH_BUF_DEPTH_MAX = 16;

   typedef logic [XLEN-1:0] word;

   typedef struct packed {
      word pc;
      word pc4;
      word inst;
   } fetch_entry_t;

endpackage : rv32

// File: rtl/fetch_buffer_ptr.sv
// fetch_buffer_ptr: pointer counter that wraps at DEPTH (works for non power-of-two depths).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : advance pointer by one (wraps DEPTH-1 -> 0)
//   clr        : return pointer to 0; wins over inc
//   ptr        : current pointer value
module fetch_buffer_ptr #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [PTR_W-1:0] ptr
);

   localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

   // Explicit compare so depths like 3 or 5 wrap correctly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (clr) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= (ptr == LAST) ? '0 : ptr + PTR_W'(1);
      end
   end

endmodule : fetch_buffer_ptr

// File: rtl/fetch_buffer.sv
// fetch_buffer: DEPTH-entry circular queue between fetch and decode.
// Fetch may run ahead while decode stalls; squash empties the queue in one cycle.
// Optional build macro: FETCH_BUFFER_BYPASS_EN - when the queue is empty and decode
// is not stalled, the fetched entry is forwarded combinationally (0-cycle latency)
// and not stored.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   stall                      : decode cannot accept; hold the head entry
//   squash                     : flush all entries (redirect)
//   bubble_i, pc_i, pc4_i, inst_i : fetch slot (bubble_i = 1 means empty slot)
//   ready_o                    : buffer can accept a push this cycle
//   bubble_o                   : no valid head presented to decode
//   pc_o, pc4_o, inst_o        : head entry
//   level_o                    : current occupancy 0..DEPTH
module fetch_buffer
   import rv32::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             squash,
   input  logic             bubble_i,
   input  word              pc_i,
   input  word              pc4_i,
   input  word              inst_i,
   output logic             ready_o,
   output logic             bubble_o,
   output word              pc_o,
   output word              pc4_o,
   output word              inst_o,
   output logic [CNT_W-1:0] level_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             push;
   logic             pop;
   fetch_entry_t     head;
   fetch_entry_t     in_entry;

   assign in_entry = '{pc: pc_i, pc4: pc4_i, inst: inst_i};
   assign ready_o  = (count != FULL);
   assign pop      = !stall && (count != '0) && !squash;

`ifdef FETCH_BUFFER_BYPASS_EN
   // Empty queue and a willing decode: hand the slot straight through.
   logic bypass;
   assign bypass = rst_n && (count == '0) && !bubble_i && !stall && !squash;
   assign push   = !bubble_i && ready_o && !squash && !bypass;
`else
   assign push   = !bubble_i && ready_o && !squash;
`endif

   fetch_buffer_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (push),
      .clr   (squash),
      .ptr   (wr_ptr)
   );

   fetch_buffer_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (pop),
      .clr   (squash),
      .ptr   (rd_ptr)
   );

   // Occupancy; squash discards any concurrent push/pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (squash) begin
         count <= '0;
      end else begin
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Entry storage, cleared on reset so outputs read 0 while in reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else if (push) begin
         mem[wr_ptr] <= in_entry;
      end
   end

   // Head selection.
   always_comb begin
      head     = mem[rd_ptr];
      bubble_o = (count == '0);
`ifdef FETCH_BUFFER_BYPASS_EN
      if (bypass) begin
         head     = in_entry;
         bubble_o = 1'b0;
      end
`endif
   end

   assign pc_o    = head.pc;
   assign pc4_o   = head.pc4;
   assign inst_o  = head.inst;
   assign level_o = count;

endmodule : fetch_buffer

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed self-checking bench for fetch_buffer.
// Instance a: DEPTH = 2 (reset, stream, backpressure, squash, async reset, bypass).
// Instance b: DEPTH = 3 (ordering across repeated pointer wrap).
module tb_fetch_buffer;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   // Instance a signals
   logic        a_stall, a_squash, a_bub;
   logic [31:0] a_pc, a_pc4, a_inst;
   logic        a_ready, a_bubble_o;
   logic [31:0] a_pc_o, a_pc4_o, a_inst_o;
   logic [1:0]  a_level;

   // Instance b signals
   logic        b_stall, b_squash, b_bub;
   logic [31:0] b_pc, b_pc4, b_inst;
   logic        b_ready, b_bubble_o;
   logic [31:0] b_pc_o, b_pc4_o, b_inst_o;
   logic [1:0]  b_level;

   int checks   = 0;
   int failures = 0;

   fetch_buffer #(.DEPTH(2)) u_dut_a (
      .clk      (clk),
      .rst_n    (rst_n),
      .stall    (a_stall),
      .squash   (a_squash),
      .bubble_i (a_bub),
      .pc_i     (a_pc),
      .pc4_i    (a_pc4),
      .inst_i   (a_inst),
      .ready_o  (a_ready),
      .bubble_o (a_bubble_o),
      .pc_o     (a_pc_o),
      .pc4_o    (a_pc4_o),
      .inst_o   (a_inst_o),
      .level_o  (a_level)
   );

   fetch_buffer #(.DEPTH(3)) u_dut_b (
      .clk      (clk),
      .rst_n    (rst_n),
      .stall    (b_stall),
      .squash   (b_squash),
      .bubble_i (b_bub),
      .pc_i     (b_pc),
      .pc4_i    (b_pc4),
      .inst_i   (b_inst),
      .ready_o  (b_ready),
      .bubble_o (b_bubble_o),
      .pc_o     (b_pc_o),
      .pc4_o    (b_pc4_o),
      .inst_o   (b_inst_o),
      .level_o  (b_level)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic bub, input logic [31:0] pc);
      a_bub  = bub;
      a_pc   = pc;
      a_pc4  = pc + 32'd4;
      a_inst = 32'h0000_0013;
   endtask

   initial begin
      logic [31:0] stall_pat;
      int          next_idx;
      int          rd_idx;
      int          cyc;

      rst_n    = 1'b0;
      a_stall  = 1'b0;
      a_squash = 1'b0;
      drive_a(1'b1, 32'h0);
      b_stall  = 1'b0;
      b_squash = 1'b0;
      b_bub    = 1'b1;
      b_pc     = '0;
      b_pc4    = '0;
      b_inst   = '0;

      // Reset values, during and after reset
      #3;
      check("rst_bubble", 32'(a_bubble_o), 32'd1);
      check("rst_ready",  32'(a_ready),    32'd1);
      check("rst_level",  32'(a_level),    32'd0);
      check("rst_pc",     a_pc_o,          32'd0);
      #14 rst_n = 1'b1;
      tick();
      check("post_rst_bubble", 32'(a_bubble_o), 32'd1);
      check("post_rst_ready",  32'(a_ready),    32'd1);
      check("post_rst_level",  32'(a_level),    32'd0);
      check("post_rst_inst",   a_inst_o,        32'd0);

      // Stream at 1 instruction/cycle
      for (int k = 0; k < 3; k++) begin
         drive_a(1'b0, 32'h100 + 32'(k * 4));
         #1;
`ifdef FETCH_BUFFER_BYPASS_EN
         check("stream_byp_pc",     a_pc_o,          32'h100 + 32'(k * 4));
         check("stream_byp_bubble", 32'(a_bubble_o), 32'd0);
         check("stream_byp_level",  32'(a_level),    32'd0);
`endif
         tick();
`ifndef FETCH_BUFFER_BYPASS_EN
         check("stream_pc",     a_pc_o,          32'h100 + 32'(k * 4));
         check("stream_pc4",    a_pc4_o,         32'h104 + 32'(k * 4));
         check("stream_inst",   a_inst_o,        32'h0000_0013);
         check("stream_bubble", 32'(a_bubble_o), 32'd0);
         check("stream_level",  32'(a_level),    32'd1);
`endif
      end
      drive_a(1'b1, 32'h0);
      tick();
      check("stream_drain_bubble", 32'(a_bubble_o), 32'd1);
      check("stream_drain_level",  32'(a_level),    32'd0);

      // Backpressure: fill under stall, third entry held by fetch
      a_stall = 1'b1;
      drive_a(1'b0, 32'h400);
      tick();
      check("bp1_level", 32'(a_level), 32'd1);
      check("bp1_ready", 32'(a_ready), 32'd1);
      check("bp1_pc",    a_pc_o,       32'h400);
      drive_a(1'b0, 32'h404);
      tick();
      check("bp2_level", 32'(a_level), 32'd2);
      check("bp2_ready", 32'(a_ready), 32'd0);
      drive_a(1'b0, 32'h408);
      tick();
      check("bp3_level", 32'(a_level), 32'd2);
      check("bp3_ready", 32'(a_ready), 32'd0);
      check("bp3_hold_pc", a_pc_o,     32'h400);
      a_stall = 1'b0;
      tick();
      check("drain1_pc",    a_pc_o,       32'h404);
      check("drain1_level", 32'(a_level), 32'd1);
      check("drain1_ready", 32'(a_ready), 32'd1);
      tick();
      check("drain2_pc",    a_pc_o,       32'h408);
      check("drain2_level", 32'(a_level), 32'd1);
      drive_a(1'b1, 32'h0);
      tick();
      check("drain3_bubble", 32'(a_bubble_o), 32'd1);

      // Squash when full, with a push offered
      a_stall = 1'b1;
      drive_a(1'b0, 32'h500);
      tick();
      drive_a(1'b0, 32'h504);
      tick();
      check("sq_full_level", 32'(a_level), 32'd2);
      a_squash = 1'b1;
      drive_a(1'b0, 32'h200);
      tick();
      check("sq_full_bubble", 32'(a_bubble_o), 32'd1);
      check("sq_full_level0", 32'(a_level),    32'd0);
      check("sq_full_ready",  32'(a_ready),    32'd1);
      a_squash = 1'b0;
      drive_a(1'b1, 32'h0);
      tick();
      check("sq_full_no200", 32'(a_bubble_o), 32'd1);

      // Squash with room: concurrent push of 0x204 is discarded
      drive_a(1'b0, 32'h508);
      tick();
      a_squash = 1'b1;
      drive_a(1'b0, 32'h204);
      tick();
      check("sq_part_bubble", 32'(a_bubble_o), 32'd1);
      check("sq_part_level",  32'(a_level),    32'd0);
      a_squash = 1'b0;
      drive_a(1'b0, 32'h600);
      tick();
      check("post_sq_pc",    a_pc_o,       32'h600);
      check("post_sq_level", 32'(a_level), 32'd1);

      // Asynchronous reset mid-operation, no clock edge needed
      drive_a(1'b1, 32'h0);
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_bubble", 32'(a_bubble_o), 32'd1);
      check("async_rst_level",  32'(a_level),    32'd0);
      check("async_rst_ready",  32'(a_ready),    32'd1);
      check("async_rst_pc",     a_pc_o,          32'd0);
      @(negedge clk);
      rst_n   = 1'b1;
      a_stall = 1'b0;
      tick();

      // Bypass latency from empty
      drive_a(1'b0, 32'h300);
      #1;
`ifdef FETCH_BUFFER_BYPASS_EN
      check("byp_same_pc",     a_pc_o,          32'h300);
      check("byp_same_bubble", 32'(a_bubble_o), 32'd0);
`else
      check("nobyp_same_bubble", 32'(a_bubble_o), 32'd1);
      tick();
      check("nobyp_next_pc",     a_pc_o,          32'h300);
      check("nobyp_next_bubble", 32'(a_bubble_o), 32'd0);
`endif
      drive_a(1'b1, 32'h0);
      tick();

      // DEPTH=3 ordering under varying stall, 12 entries (4 pointer wraps)
      stall_pat = 32'b0110_0011_1000_1101_0010_0111_0001_1100;
      next_idx  = 0;
      rd_idx    = 0;
      cyc       = 0;
      while (rd_idx < 12 && cyc < 200) begin
         b_stall = stall_pat[cyc % 32];
         b_bub   = (next_idx >= 12);
         b_pc    = 32'h1000 + 32'(next_idx * 4);
         b_pc4   = b_pc + 32'd4;
         b_inst  = 32'h0000_0013;
         #1;
         if (!b_bubble_o && !b_stall) begin
            check("wrap_order_pc", b_pc_o, 32'h1000 + 32'(rd_idx * 4));
            rd_idx++;
         end
         if (!b_bub && b_ready) begin
            next_idx++;
         end
         tick();
         cyc++;
      end
      check("wrap_all_drained", 32'(rd_idx), 32'd12);
      b_bub   = 1'b1;
      b_stall = 1'b0;
      tick();
      check("wrap_end_level", 32'(b_level), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_fetch_buffer

// File: doc/fetch_buffer.md
# fetch_buffer

Parametrised fetch-to-decode buffer with a DEPTH-entry circular queue in place of a single-entry IF/ID register. Fetch can run ahead while decode stalls, and a squash flushes every queued instruction in one cycle. The block sits between the fetch stage (PC generation and instruction memory) and the decode stage. It carries the same PC, PC+4 and instruction payload with bubble semantics, and adds backpressure and occupancy reporting.

## Interface
Parameters:
- DEPTH, 2, number of queued entries; legal range 2..16, any integer (not restricted to powers of two).
- CNT_W, $clog2(DEPTH+1), width of the occupancy count; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock (the block's only clock).
- rst_n  input  1  reset; asynchronous assertion, active-low.
- stall  input  1  decode cannot accept; 1 = hold the head entry.
- squash  input  1  flush all entries (branch/trap redirect).
- bubble_i  input  1  1 = fetch slot carries no instruction.
- pc_i  input  32 (rv32::word)  fetched PC.
- pc4_i  input  32 (rv32::word)  fetched PC+4.
- inst_i  input  32 (rv32::word)  fetched instruction.
- ready_o  output  1  buffer can accept a push this cycle.
- bubble_o  output  1  1 = no valid head entry presented to decode.
- pc_o  output  32  head PC.
- pc4_o  output  32  head PC+4.
- inst_o  output  32  head instruction.
- level_o  output  CNT_W  current occupancy, 0..DEPTH.

## Operation
- State: storage array[DEPTH] of {pc, pc4, inst}, wr_ptr and rd_ptr (each $clog2(DEPTH) bits), and count (CNT_W bits).
- push = !bubble_i && ready_o && !squash.
- pop = !stall && (count != 0) && !squash.
- ready_o = (count != DEPTH). It is derived from registered state only and does not depend on stall in the same cycle.
- A push while full is impossible by construction. Fetch must hold its slot while ready_o = 0; the buffer does not drop data.
- Pointer wrap: ptr == DEPTH-1 advances to 0 (explicit compare, not natural overflow).
- count_next = count + push - pop. Simultaneous push and pop leave count unchanged; both pointers advance.
- squash has priority over everything. Next cycle: count = 0, rd_ptr = wr_ptr = 0, and any concurrent push or pop is discarded.
- bubble_o = (count == 0).
- pc_o, pc4_o and inst_o are the entry at rd_ptr. Their values are don't-care when bubble_o = 1.
- Reset (rst_n low, asynchronous): count = 0, pointers = 0, storage cleared to 0.
- Output values during reset: bubble_o = 1, ready_o = 1, level_o = 0, pc_o = pc4_o = inst_o = 0.
- Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.

## Timing
- Push-to-present latency is 1 cycle: an entry pushed at edge N is visible with bubble_o = 0 after edge N.
- Occupancy 1 with stall = 0 and a concurrent push: the old head pops, the new entry becomes head. This sustains 1 instruction/cycle with no gap.
- While stall = 1, the head outputs remain stable cycle to cycle.
- Full with pop and no push: ready_o rises the cycle after the pop.
- squash at edge N: bubble_o = 1 and ready_o = 1 after edge N. The first post-redirect fetch can push at edge N+1.

## Configuration
- FETCH_BUFFER_BYPASS_EN defined:
  - When count == 0, !bubble_i, !stall and !squash, the input drives the outputs combinationally and bubble_o = 0 in the same cycle; the entry is not stored.
  - Fetch-to-decode latency is 0 in that case.
  - pc_o, pc4_o, inst_o and bubble_o then have a combinational path from the inputs.
- Not defined: every entry passes through storage; latency is always 1; all outputs come from registers or storage only.

## Structure
- Add to rv32 package: typedef fetch_entry_t (packed struct {word pc; word pc4; word inst}).
- Add to rv32 package: constant FETCH_BUF_DEPTH_MAX = 16.
- Natural sub-module: fetch_buffer_ptr, a wrap-at-DEPTH pointer counter (inc, clr), instantiated twice.

## Test plan
- Reset with DEPTH = 2: after rst_n rises, bubble_o = 1, ready_o = 1, level_o = 0, inst_o = 0.
- Stream: push 0x00000013 at PC 0x100, 0x104, 0x108 in consecutive cycles with stall = 0. Decode must see PCs 0x100, 0x104, 0x108 on consecutive cycles, level_o stays at 1, and bubble_o stays 0 throughout.
- Backpressure: stall = 1, then push 3 entries with DEPTH = 2. Required response: ready_o = 0 after 2 pushes, level_o = 2, and the third entry is held by fetch. After stall drops, entries drain in order.
- Wrap, with DEPTH = 3: run 10 push/pop cycles at varying stall duty. Output PC order must equal input order, crossing pointer wrap at least 3 times.
- Squash when full: squash = 1 with a concurrent push of PC 0x200. Next cycle bubble_o = 1, level_o = 0, and 0x200 is never presented.
- Bypass: with FETCH_BUFFER_BYPASS_EN, when empty, pc_i = 0x300 must appear on pc_o in the same cycle with bubble_o = 0. Without the macro, it appears one cycle later.
